seg_display_mux: RTL and testbench

//  Parametrised time-multiplexed hex display driver for NUM_DIGITS common-anode 7-seg digits.

---
 rtl/seg_display_mux.sv | 220 ++++++++++++++++++++++
 tb/tb_seg_display_mux.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// Time-multiplexed hex display driver for common-anode 7-segment digits.
// Scans digits from the leftmost (NUM_DIGITS-1) down to 0, one DIGIT_CYCLES slot each.
// The display value is double-buffered: load writes a shadow copy, and the shadow is
// promoted to the active copy only on the frame boundary, so a frame never tears.
// Segment and anode outputs are registered together, so they switch on the same edge.

module seg_display_mux #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_CYCLES = 2500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [3:0]                brightness,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int unsigned TickW      = $clog2(DIGIT_CYCLES);
    localparam int unsigned DigW       = $clog2(NUM_DIGITS);
    localparam int unsigned ThrW       = TickW + 1;
    // One brightness step is 1/16 of a digit slot.
    localparam int unsigned StepCycles = DIGIT_CYCLES / 16;

    localparam logic [TickW-1:0] TickLast = TickW'(DIGIT_CYCLES - 1);
    localparam logic [DigW-1:0]  DigLast  = DigW'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TickW-1:0]          tick_q, tick_d;
    logic [DigW-1:0]           k_q, k_d;

    logic [4*NUM_DIGITS-1:0]   shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0]   active_data_q, active_data_d;
    logic [NUM_DIGITS-1:0]     active_dp_q, active_dp_d;

    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      frame_done_q, frame_done_d;

    // Scan control
    logic                      tick_last;
    logic                      digit_last;
    logic                      frame_end;

    // Per-slot decode helpers
    logic [NUM_DIGITS-1:0]     zero_run;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_blank;
    logic [ThrW-1:0]           pwm_thresh;
    logic                      pwm_on;

    // ------------------------------------------------------------------
    // Hex to abcdefg, active-low (0 = segment lit)
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scan counters: tick within a slot, k steps down, frame ends after digit 0
    // ------------------------------------------------------------------
    always_comb begin
        tick_last  = (tick_q == TickLast);
        digit_last = (k_q == '0);
        frame_end  = tick_last && digit_last;

        tick_d = tick_q + 1'b1;
        k_d    = k_q;
        if (tick_last) begin
            tick_d = '0;
            k_d    = digit_last ? DigLast : (k_q - 1'b1);
        end
    end

    // Next-state for the double buffer and the reload pulse
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        active_data_d = active_data_q;
        active_dp_d   = active_dp_q;

        if (load) begin
            shadow_data_d = data_in;
            shadow_dp_d   = dp_in;
        end
        // Promotion reads the pre-edge shadow, so a load on the boundary edge
        // is deferred to the following frame.
        if (frame_end) begin
            active_data_d = shadow_data_q;
            active_dp_d   = shadow_dp_q;
        end

        frame_done_d = frame_end;
    end

    // Leading-zero detection: zero_run[j] means digit j and every digit above it are 0
    always_comb begin
        zero_run = '0;
        zero_run[NUM_DIGITS-1] = (active_data_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int j = int'(NUM_DIGITS) - 2; j >= 0; j--) begin
            zero_run[j] = zero_run[j+1] && (active_data_q[4*j +: 4] == 4'h0);
        end

        blank_mask    = blank_lz ? zero_run : '0;
        // The units digit always shows, so an all-zero value reads as "0".
        blank_mask[0] = 1'b0;
    end

    // Select the nibble, decimal point and blanking flag for the digit being scanned
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int j = 0; j < int'(NUM_DIGITS); j++) begin
            if (k_q == DigW'(j)) begin
                cur_nib   = active_data_q[4*j +: 4];
                cur_dp    = active_dp_q[j];
                cur_blank = blank_mask[j];
            end
        end
    end

    // PWM gate: anode enabled for the first (brightness+1)/16 of the slot
    always_comb begin
        pwm_thresh = ThrW'((32'(brightness) + 32'd1) * StepCycles);
        pwm_on     = ({1'b0, tick_q} < pwm_thresh);
    end

    // Output next-state: segment pattern and one-hot-low anode for the current slot
    always_comb begin
        seg_d[7:1] = cur_blank ? 7'b1111111 : hex_to_seg(cur_nib);
        seg_d[0]   = ~cur_dp;

        an_d = '1;
        for (int j = 0; j < int'(NUM_DIGITS); j++) begin
            if (pwm_on && (k_q == DigW'(j))) begin
                an_d[j] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Scan position; reset restarts at the leftmost digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
            k_q    <= DigLast;
        end else begin
            tick_q <= tick_d;
            k_q    <= k_d;
        end
    end

    // Shadow and active display buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            active_data_q <= '0;
            active_dp_q   <= '0;
        end else begin
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
        end
    end

    // Registered pin drivers; reset forces the display dark immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= 8'hFF;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with NUM_DIGITS=4, DIGIT_CYCLES=32.
// A frame is 128 cycles; the bench samples on the falling edge.

module tb_seg_display_mux;

    localparam int unsigned ND = 4;
    localparam int unsigned DC = 32;
    localparam int FRAME = 128;

    logic              clk;
    logic              rst_n;
    logic [4*ND-1:0]   data_in;
    logic [ND-1:0]     dp_in;
    logic              load;
    logic              blank_lz;
    logic [3:0]        brightness;
    logic [7:0]        seg;
    logic [ND-1:0]     an;
    logic              frame_done;

    int checks   = 0;
    int failures = 0;

    seg_display_mux #(
        .NUM_DIGITS   (ND),
        .DIGIT_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        blank;
        logic [3:0]  bright;
        logic [7:0]  s3;
        logic [7:0]  s2;
        logic [7:0]  s1;
        logic [7:0]  s0;
        int          low;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge that sees frame_done high (bounded)
    task automatic wait_fd();
        int n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_seen", int'(frame_done === 1'b1), 1);
    endtask

    // Called right after a frame_done sample; checks one whole frame of output
    task automatic scan_frame(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0, input int low);
        logic [7:0] es[4];
        logic [7:0] bad_seg[4];
        int         seg_err[4];
        int         an_err[4];
        int         fd_err;
        int         k;
        int         t;
        logic [3:0] an_exp;
        es = '{s0, s1, s2, s3};
        fd_err = 0;
        for (int j = 0; j < 4; j++) begin
            seg_err[j] = 0;
            an_err[j]  = 0;
            bad_seg[j] = 8'h00;
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            k = 3 - i / 32;
            t = i % 32;
            an_exp = (t < low) ? ~(4'b0001 << k) : 4'hF;
            if (seg !== es[k]) begin
                if (seg_err[k] == 0) bad_seg[k] = seg;
                seg_err[k]++;
            end
            if (an !== an_exp) an_err[k]++;
            if (frame_done !== (i == FRAME - 1)) fd_err++;
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("%s seg digit%0d", tag, j),
                  (seg_err[j] == 0) ? int'(es[j]) : int'(bad_seg[j]), int'(es[j]));
            check($sformatf("%s an errcycles digit%0d", tag, j), an_err[j], 0);
        end
        check($sformatf("%s frame_done errcycles", tag), fd_err, 0);
    endtask

    // Called at the falling edge where rst_n is released; expects zero display, full brightness
    task automatic post_reset_scan(input string tag);
        int seg_err = 0;
        int an_err  = 0;
        int fd_err  = 0;
        int k;
        logic [7:0] first_seg;
        logic [3:0] first_an;
        first_seg = 8'h00;
        first_an  = 4'h0;
        for (int n = 1; n <= FRAME; n++) begin
            @(negedge clk);
            if (n == 1) begin
                first_seg = seg;
                first_an  = an;
            end
            k = 3 - ((n - 1) / 32);
            if (seg !== 8'h03) seg_err++;
            if (an !== ~(4'b0001 << k)) an_err++;
            if (frame_done !== (n == FRAME)) fd_err++;
        end
        check($sformatf("%s first seg", tag), int'(first_seg), 8'h03);
        check($sformatf("%s first an", tag), int'(first_an), 4'b0111);
        check($sformatf("%s seg errcycles", tag), seg_err, 0);
        check($sformatf("%s an scan errcycles", tag), an_err, 0);
        check($sformatf("%s frame_done errcycles", tag), fd_err, 0);
    endtask

    initial begin
        //               data      dp       blank bright  s3     s2     s1     s0     low
        vecs[0] = '{16'h0000, 4'b0000, 1'b0, 4'd15, 8'h03, 8'h03, 8'h03, 8'h03, 32};
        vecs[1] = '{16'h1A2F, 4'b0000, 1'b0, 4'd15, 8'h9F, 8'h11, 8'h25, 8'h71, 32};
        vecs[2] = '{16'h0045, 4'b0100, 1'b1, 4'd15, 8'hFF, 8'hFE, 8'h99, 8'h49, 32};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, 4'd3,  8'hFF, 8'hFF, 8'hFF, 8'h03, 8};
        vecs[4] = '{16'h8B3E, 4'b1001, 1'b1, 4'd0,  8'h00, 8'hC1, 8'h0D, 8'h60, 2};
        vecs[5] = '{16'h0C07, 4'b0000, 1'b1, 4'd7,  8'hFF, 8'h63, 8'h03, 8'h1F, 16};
        vecs[6] = '{16'h0D96, 4'b0000, 1'b0, 4'd15, 8'h03, 8'h85, 8'h09, 8'h41, 32};

        rst_n      = 1'b0;
        load       = 1'b0;
        data_in    = '0;
        dp_in      = '0;
        blank_lz   = 1'b0;
        brightness = 4'd15;

        // Reset state
        #23;
        check("reset seg", int'(seg), 8'hFF);
        check("reset an", int'(an), 4'hF);
        check("reset frame_done", int'(frame_done), 0);

        @(negedge clk);
        rst_n = 1'b1;
        post_reset_scan("por");

        // Table: load at the start of a frame, shown from the next frame on
        for (int v = 0; v < 7; v++) begin
            data_in    = vecs[v].data;
            dp_in      = vecs[v].dp;
            blank_lz   = vecs[v].blank;
            brightness = vecs[v].bright;
            load       = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_fd();
            scan_frame($sformatf("vec%0d", v), vecs[v].s3, vecs[v].s2, vecs[v].s1,
                       vecs[v].s0, vecs[v].low);
        end

        // Load landing on the frame-boundary edge: old value for one more frame
        repeat (127) @(negedge clk);
        data_in = 16'h1234;
        dp_in   = 4'b0000;
        load    = 1'b1;
        @(negedge clk);
        check("boundary load aligned", int'(frame_done), 1);
        load    = 1'b0;
        data_in = 16'hFFFF;
        scan_frame("bnd old", 8'h03, 8'h85, 8'h09, 8'h41, 32);
        scan_frame("bnd new", 8'h9F, 8'h25, 8'h0D, 8'h99, 32);

        // Asynchronous reset in the middle of slot k=1, tick=17
        repeat (81) @(negedge clk);
        check("pre-reset an digit1", int'(an), 4'b1101);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset seg", int'(seg), 8'hFF);
        check("async reset an", int'(an), 4'hF);
        check("async reset frame_done", int'(frame_done), 0);
        @(negedge clk);
        check("held reset an", int'(an), 4'hF);
        rst_n = 1'b1;
        post_reset_scan("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
